// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB and issue signals of the ALU reservation station.
// The station is the slave; the dispatch/CDB/ALU side is the master.
interface alu_reservation_station_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned TAG_W  = 4
);
  logic              disp_valid;
  logic              disp_ready;
  logic [SEL_W-1:0]  disp_opsel;
  logic [4:0]        disp_shamt;
  logic [TAG_W-1:0]  disp_dest_tag;
  logic              disp_src1_rdy;
  logic              disp_src2_rdy;
  logic [DATA_W-1:0] disp_src1_val;
  logic [DATA_W-1:0] disp_src2_val;
  logic [TAG_W-1:0]  disp_src1_tag;
  logic [TAG_W-1:0]  disp_src2_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              iss_valid;
  logic              iss_ready;
  logic [DATA_W-1:0] iss_operand1;
  logic [DATA_W-1:0] iss_operand2;
  logic [4:0]        iss_shamt;
  logic [SEL_W-1:0]  iss_opsel;
  logic [TAG_W-1:0]  iss_dest_tag;

  modport master (
    output disp_valid, disp_opsel, disp_shamt, disp_dest_tag,
           disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
           disp_src1_tag, disp_src2_tag,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_operand1, iss_operand2,
           iss_shamt, iss_opsel, iss_dest_tag
  );

  modport slave (
    input  disp_valid, disp_opsel, disp_shamt, disp_dest_tag,
           disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
           disp_src1_tag, disp_src2_tag,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_operand1, iss_operand2,
           iss_shamt, iss_opsel, iss_dest_tag
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Reservation station in front of the ALU: buffers ops, snoops the CDB, issues one ready op per cycle.
// Define RS_OLDEST_FIRST_EN to pick the oldest eligible entry (age matrix) instead of the lowest index.
module alu_reservation_station #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  alu_reservation_station_if.slave  rs
);

  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic              valid;
    logic [SEL_W-1:0]  opsel;
    logic [SHAMT_W-1:0] shamt;
    logic [TAG_W-1:0]  dest;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_val;
    logic              s2_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_val;
  } entry_t;

  typedef struct packed {
    logic [DATA_W-1:0]  operand1;
    logic [DATA_W-1:0]  operand2;
    logic [SHAMT_W-1:0] shamt;
    logic [SEL_W-1:0]   opsel;
    logic [TAG_W-1:0]   dest;
  } iss_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  iss_t             iss_q, iss_d;
  logic             iss_valid_q, iss_valid_d;

  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] elig_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_rdy;
  logic             disp_fire;
  logic             iss_load;
  entry_t           new_ent;

  // Occupancy and eligibility come from registered state only
  always_comb begin
    valid_vec = '0;
    elig_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      elig_vec[i]  = ent_q[i].valid && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !found) begin
        free_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign disp_rdy  = ~&valid_vec;
  assign disp_fire = rs.disp_valid && disp_rdy && !flush;
  assign iss_load  = !iss_valid_q || rs.iss_ready;

`ifdef RS_OLDEST_FIRST_EN
  // age_q[i][j] set: entry i was dispatched before entry j
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  always_comb begin
    logic has_older;
    logic found;
    has_older = 1'b0;
    found     = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      has_older = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && elig_vec[j] && age_q[j][i]) has_older = 1'b1;
      end
      if (elig_vec[i] && !has_older && !found) begin
        sel_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
    if (disp_fire) begin
      for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = valid_vec[j];
      age_d[free_idx] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end
`else
  always_comb begin
    logic found;
    found   = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig_vec[i] && !found) begin
        sel_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end
`endif

  // Incoming entry, with a same-cycle CDB match captured so no wakeup is lost
  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.opsel  = rs.disp_opsel;
    new_ent.shamt  = rs.disp_shamt;
    new_ent.dest   = rs.disp_dest_tag;
    new_ent.s1_rdy = rs.disp_src1_rdy;
    new_ent.s1_tag = rs.disp_src1_tag;
    new_ent.s1_val = rs.disp_src1_val;
    new_ent.s2_rdy = rs.disp_src2_rdy;
    new_ent.s2_tag = rs.disp_src2_tag;
    new_ent.s2_val = rs.disp_src2_val;
    if (rs.cdb_valid && !rs.disp_src1_rdy && (rs.disp_src1_tag == rs.cdb_tag)) begin
      new_ent.s1_rdy = 1'b1;
      new_ent.s1_val = rs.cdb_data;
    end
    if (rs.cdb_valid && !rs.disp_src2_rdy && (rs.disp_src2_tag == rs.cdb_tag)) begin
      new_ent.s2_rdy = 1'b1;
      new_ent.s2_val = rs.cdb_data;
    end
  end

  // Issue, wakeup and dispatch; flush overrides everything
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    iss_d       = iss_q;
    iss_valid_d = iss_valid_q;

    if (iss_load) begin
      if (|elig_vec) begin
        iss_d.operand1        = ent_q[sel_idx].s1_val;
        iss_d.operand2        = ent_q[sel_idx].s2_val;
        iss_d.shamt           = ent_q[sel_idx].shamt;
        iss_d.opsel           = ent_q[sel_idx].opsel;
        iss_d.dest            = ent_q[sel_idx].dest;
        iss_valid_d           = 1'b1;
        ent_d[sel_idx].valid  = 1'b0;
      end else begin
        iss_valid_d = 1'b0;
      end
    end

    if (rs.cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && !ent_q[i].s1_rdy && (ent_q[i].s1_tag == rs.cdb_tag)) begin
          ent_d[i].s1_rdy = 1'b1;
          ent_d[i].s1_val = rs.cdb_data;
        end
        if (ent_q[i].valid && !ent_q[i].s2_rdy && (ent_q[i].s2_tag == rs.cdb_tag)) begin
          ent_d[i].s2_rdy = 1'b1;
          ent_d[i].s2_val = rs.cdb_data;
        end
      end
    end

    if (disp_fire) ent_d[free_idx] = new_ent;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      iss_q       <= iss_d;
      iss_valid_q <= iss_valid_d;
    end
  end

  assign rs.disp_ready   = disp_rdy;
  assign rs.iss_valid    = iss_valid_q;
  assign rs.iss_operand1 = iss_q.operand1;
  assign rs.iss_operand2 = iss_q.operand2;
  assign rs.iss_shamt    = iss_q.shamt;
  assign rs.iss_opsel    = iss_q.opsel;
  assign rs.iss_dest_tag = iss_q.dest;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed + randomized bench for alu_reservation_station against a slot/sequence-number reference model.
module tb_alu_reservation_station;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_reservation_station_if #(.DATA_W(32), .SEL_W(4), .TAG_W(4)) bus ();

  alu_reservation_station #(.DATA_W(32), .SEL_W(4), .TAG_W(4), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .rs    (bus)
  );

  typedef struct {
    bit          v;
    bit          r1;
    bit          r2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  t1;
    logic [3:0]  t2;
    logic [3:0]  op;
    logic [3:0]  dest;
    logic [4:0]  sh;
    int          seq;
  } slot_t;

  slot_t       m [DEPTH];
  bit          m_iss_valid;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_sh;
  logic [3:0]  m_sel, m_dest;
  int          seq_ctr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_has_free();
    bit r = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (!m[i].v) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '{default: '0};
    m_iss_valid = 1'b0;
    seq_ctr     = 0;
  endtask

  // One clock edge of the reference behaviour, from the inputs currently driven
  task automatic model_step();
    int  pick;
    int  free;
    bit  can_disp;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
      m_iss_valid = 1'b0;
      return;
    end
    can_disp = m_has_free();
    free = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].v) free = i;
    if (!m_iss_valid || bus.iss_ready) begin
      pick = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef RS_OLDEST_FIRST_EN
          if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
          if (pick < 0) pick = i;
`endif
        end
      end
      if (pick >= 0) begin
        m_op1 = m[pick].v1; m_op2 = m[pick].v2; m_sh = m[pick].sh;
        m_sel = m[pick].op; m_dest = m[pick].dest;
        m[pick].v   = 1'b0;
        m_iss_valid = 1'b1;
      end else begin
        m_iss_valid = 1'b0;
      end
    end
    if (bus.cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].v && !m[i].r1 && m[i].t1 == bus.cdb_tag) begin m[i].r1 = 1'b1; m[i].v1 = bus.cdb_data; end
        if (m[i].v && !m[i].r2 && m[i].t2 == bus.cdb_tag) begin m[i].r2 = 1'b1; m[i].v2 = bus.cdb_data; end
      end
    end
    if (bus.disp_valid && can_disp) begin
      m[free].v = 1'b1; m[free].op = bus.disp_opsel; m[free].sh = bus.disp_shamt;
      m[free].dest = bus.disp_dest_tag;
      m[free].r1 = bus.disp_src1_rdy; m[free].v1 = bus.disp_src1_val; m[free].t1 = bus.disp_src1_tag;
      m[free].r2 = bus.disp_src2_rdy; m[free].v2 = bus.disp_src2_val; m[free].t2 = bus.disp_src2_tag;
      if (bus.cdb_valid && !m[free].r1 && m[free].t1 == bus.cdb_tag) begin m[free].r1 = 1'b1; m[free].v1 = bus.cdb_data; end
      if (bus.cdb_valid && !m[free].r2 && m[free].t2 == bus.cdb_tag) begin m[free].r2 = 1'b1; m[free].v2 = bus.cdb_data; end
      m[free].seq = seq_ctr;
      seq_ctr++;
    end
  endtask

  task automatic compare_all();
    chk("disp_ready", 64'(bus.disp_ready), 64'(m_has_free()));
    chk("iss_valid", 64'(bus.iss_valid), 64'(m_iss_valid));
    if (m_iss_valid) begin
      chk("iss_operand1", 64'(bus.iss_operand1), 64'(m_op1));
      chk("iss_operand2", 64'(bus.iss_operand2), 64'(m_op2));
      chk("iss_shamt", 64'(bus.iss_shamt), 64'(m_sh));
      chk("iss_opsel", 64'(bus.iss_opsel), 64'(m_sel));
      chk("iss_dest_tag", 64'(bus.iss_dest_tag), 64'(m_dest));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [4:0] sh, input logic [3:0] dest,
                      input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                      input bit r2, input logic [31:0] v2, input logic [3:0] t2);
    bus.disp_valid = 1'b1; bus.disp_opsel = op; bus.disp_shamt = sh; bus.disp_dest_tag = dest;
    bus.disp_src1_rdy = r1; bus.disp_src1_val = v1; bus.disp_src1_tag = t1;
    bus.disp_src2_rdy = r2; bus.disp_src2_val = v2; bus.disp_src2_tag = t2;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_data = data;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.iss_ready = 1'b1;
    disp(4'd0, 5'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
    bus.disp_valid = 1'b0;
    cdb(4'd0, 32'd0);
    bus.cdb_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("reset_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("reset_operand1", 64'(bus.iss_operand1), 64'd0);
    chk("reset_dest", 64'(bus.iss_dest_tag), 64'd0);
    reset = 1'b0;

    // ADD with both sources ready: issue after the second edge
    disp(4'b0000, 5'd0, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    tick();
    chk("add_not_yet", 64'(bus.iss_valid), 64'd0);
    idle();
    tick();
    chk("add_valid", 64'(bus.iss_valid), 64'd1);
    chk("add_op1", 64'(bus.iss_operand1), 64'd5);
    chk("add_op2", 64'(bus.iss_operand2), 64'd7);
    chk("add_opsel", 64'(bus.iss_opsel), 64'd0);
    chk("add_dest", 64'(bus.iss_dest_tag), 64'd3);
    tick();
    chk("add_drained", 64'(bus.iss_valid), 64'd0);

    // SUB woken by CDB one cycle after dispatch
    disp(4'b0001, 5'd0, 4'd4, 1'b1, 32'd10, 4'd0, 1'b0, 32'd0, 4'd6);
    tick();
    idle();
    cdb(4'd6, 32'd4);
    tick();
    chk("sub_no_forward", 64'(bus.iss_valid), 64'd0);
    idle();
    tick();
    chk("sub_valid", 64'(bus.iss_valid), 64'd1);
    chk("sub_op1", 64'(bus.iss_operand1), 64'd10);
    chk("sub_op2", 64'(bus.iss_operand2), 64'd4);
    chk("sub_opsel", 64'(bus.iss_opsel), 64'd1);
    tick();

    // Same-cycle CDB capture at dispatch
    disp(4'd0, 5'd0, 4'd5, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0);
    cdb(4'd2, 32'hFFFF_FFFF);
    tick();
    idle();
    tick();
    chk("bypass_valid", 64'(bus.iss_valid), 64'd1);
    chk("bypass_op1", 64'(bus.iss_operand1), 64'hFFFF_FFFF);
    tick();

    // Fill all entries waiting on tag 9, then drain them back-to-back
    for (int k = 0; k < DEPTH; k++) begin
      disp(4'd2, 5'(k), 4'(8 + k), 1'b0, 32'd0, 4'd9, 1'b1, 32'(100 + k), 4'd0);
      tick();
    end
    chk("full_not_ready", 64'(bus.disp_ready), 64'd0);
    disp(4'd3, 5'd0, 4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
    tick();
    chk("full_still", 64'(bus.disp_ready), 64'd0);
    idle();
    cdb(4'd9, 32'h1234_5678);
    tick();
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      chk("drain_valid", 64'(bus.iss_valid), 64'd1);
      chk("drain_dest", 64'(bus.iss_dest_tag), 64'(8 + k));
      chk("drain_op1", 64'(bus.iss_operand1), 64'h1234_5678);
      chk("drain_ready", 64'(bus.disp_ready), 64'd1);
    end
    tick();
    chk("drain_empty", 64'(bus.iss_valid), 64'd0);

    // Stall holds outputs; flush squashes and drops a same-cycle dispatch
    bus.iss_ready = 1'b0;
    disp(4'd2, 5'd3, 4'd6, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0);
    tick();
    disp(4'd4, 5'd1, 4'd7, 1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 64'(bus.iss_valid), 64'd1);
      chk("stall_op1", 64'(bus.iss_operand1), 64'h11);
      chk("stall_op2", 64'(bus.iss_operand2), 64'h22);
      chk("stall_dest", 64'(bus.iss_dest_tag), 64'd6);
    end
    disp(4'd5, 5'd0, 4'd8, 1'b1, 32'h55, 4'd0, 1'b1, 32'h66, 4'd0);
    flush = 1'b1;
    tick();
    chk("flush_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("flush_disp_ready", 64'(bus.disp_ready), 64'd1);
    idle();
    bus.iss_ready = 1'b1;
    tick();
    chk("flush_dropped", 64'(bus.iss_valid), 64'd0);
    tick();

    // Selection order: B (older, entry 1) vs C (younger, entry 0)
    disp(4'd0, 5'd0, 4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    tick();
    disp(4'd0, 5'd0, 4'd2, 1'b0, 32'd0, 4'd12, 1'b1, 32'd2, 4'd0);
    tick();
    disp(4'd0, 5'd0, 4'd3, 1'b0, 32'd0, 4'd12, 1'b1, 32'd3, 4'd0);
    tick();
    idle();
    cdb(4'd12, 32'hABCD);
    tick();
    idle();
    tick();
`ifdef RS_OLDEST_FIRST_EN
    chk("order_first", 64'(bus.iss_dest_tag), 64'd2);
`else
    chk("order_first", 64'(bus.iss_dest_tag), 64'd3);
`endif
    tick();
`ifdef RS_OLDEST_FIRST_EN
    chk("order_second", 64'(bus.iss_dest_tag), 64'd3);
`else
    chk("order_second", 64'(bus.iss_dest_tag), 64'd2);
`endif
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      disp(4'($urandom_range(0, 9)), 5'($urandom), 4'($urandom),
           ($urandom_range(0, 2) != 0), $urandom, 4'($urandom_range(0, 7)),
           ($urandom_range(0, 2) != 0), $urandom, 4'($urandom_range(0, 7)));
      bus.disp_valid = ($urandom_range(0, 1) == 1);
      cdb(4'($urandom_range(0, 7)), $urandom);
      bus.cdb_valid  = ($urandom_range(0, 9) < 4);
      bus.iss_ready  = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 49) == 0);
      tick();
    end

    // Asynchronous reset in the middle of activity
    idle();
    bus.iss_ready = 1'b0;
    disp(4'd1, 5'd0, 4'd9, 1'b1, 32'h77, 4'd0, 1'b1, 32'h88, 4'd0);
    tick();
    tick();
    idle();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("async_rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("async_rst_op1", 64'(bus.iss_operand1), 64'd0);
    model_reset();
    #2 reset = 1'b0;
    bus.iss_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Buffers up to DEPTH dispatched integer operations in front of the combinational ALU.
- Snoops the common data bus (CDB) for outstanding source tags.
- Selects one ready entry per cycle and drives registered operand1/operand2/shamt/opSel (plus destination tag) into the ALU.
- Sits between the dispatch stage and the ALU; it is the producer side of the ALU operand/opSel interface.

Parameters:
- DATA_W, 32, operand/result width.
- SEL_W, 4, ALU opSel width; encodings 0000 ADD … 1001 SRL, passed through unmodified.
- TAG_W, 4, rename tag width.
- DEPTH, 4, number of entries (2..8).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all entries and the issue register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry.
- disp_opsel  in  SEL_W  ALU operation.
- disp_shamt  in  5  shift amount.
- disp_dest_tag  in  TAG_W  result tag.
- disp_src1_rdy / disp_src2_rdy  in  1  source value already valid.
- disp_src1_val / disp_src2_val  in  DATA_W  source value when rdy=1.
- disp_src1_tag / disp_src2_tag  in  TAG_W  producer tag when rdy=0.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- iss_valid  out  1  issue register holds an op.
- iss_ready  in  1  downstream (ALU/writeback slot) accepts this cycle.
- iss_operand1 / iss_operand2  out  DATA_W  to ALU operand1/operand2.
- iss_shamt  out  5  to ALU shamt.
- iss_opsel  out  SEL_W  to ALU opSel.
- iss_dest_tag  out  TAG_W  tag carried with the result.

Behaviour:
- Reset (async, active-high): all entry valid bits 0, iss_valid 0, every iss_* data output 0. disp_ready is 1 after reset.
- disp_ready depends only on registered entry valid bits; it never depends on disp_valid or on an entry freed in the same cycle.
- Dispatch fires on disp_valid && disp_ready && !flush.
  - Writes the lowest-index free entry.
  - A source with rdy=0 whose tag matches cdb_tag while cdb_valid is high in the dispatch cycle is stored as ready with cdb_data. No wakeup is lost.
- Wakeup: every valid entry with a not-ready source whose tag equals cdb_tag while cdb_valid=1 captures cdb_data and sets that source ready at the edge. Already-ready sources ignore the CDB. Both sources may wake on the same broadcast.
- Select: an entry is eligible when valid and both sources are ready, evaluated on registered state only. There is no same-cycle CDB-to-issue forwarding.
- Issue register loads when !iss_valid || iss_ready.
  - Loads the selected entry and clears that entry's valid bit at the same edge.
  - If nothing is eligible, iss_valid goes 0.
- Stall: iss_valid && !iss_ready holds every iss_* output stable and selects nothing.
- Latency: an op dispatched with both sources ready at edge N appears with iss_valid=1 after edge N+1. An op woken by the CDB at edge N issues after edge N+1.
- Throughput: one issue per cycle. A freed entry is visible on disp_ready the cycle after it issues.
- Full: disp_ready=0, and disp_valid is ignored.
- Empty with iss_ready=1: iss_valid drops to 0 on the next edge.
- flush has priority over dispatch, wakeup and issue.
  - At the edge it clears all entry valid bits and iss_valid.
  - iss_* data may keep stale values but must not be qualified.
- Reset asserted mid-operation discards all state immediately.

Optional Feature:
- Macro RS_OLDEST_FIRST_EN.
- Defined: a DEPTH×DEPTH age matrix is updated at dispatch. Among eligible entries, the oldest dispatched is selected.
- Undefined: the lowest-index eligible entry is selected and no age matrix is built.
- All other timing is identical in both builds.

Test Plan:
- Dispatch ADD, src1=5 rdy, src2=7 rdy, dest=3 → iss_valid=1 after 2nd edge; iss_operand1=5, iss_operand2=7, iss_opsel=0000, iss_dest_tag=3.
- Dispatch SUB, src1 rdy=10, src2 tag=6 not ready; next cycle cdb_valid=1, cdb_tag=6, cdb_data=4 → issue one edge later with operand2=4, opsel=0001.
- Dispatch with src1 tag=2 while cdb_valid=1, cdb_tag=2, cdb_data=0xFFFF_FFFF in the same cycle → entry issues with operand1=0xFFFF_FFFF, with no further broadcast needed.
- Fill 4 entries, all waiting on tag 9, with iss_ready=1 → disp_ready=0 and a 5th disp_valid is ignored; cdb tag 9 → four issues on consecutive cycles and disp_ready returns to 1.
- Hold iss_ready=0 with 2 ready entries → iss_* stable across 3 cycles. Assert flush → iss_valid=0 and disp_ready=1 next cycle; a dispatch in the flush cycle is dropped.
- RS_OLDEST_FIRST_EN defined: dispatch A into entry 0 and B into entry 1 (both waiting), free entry 0 via another op, dispatch C into entry 0, then wake all → order B, C… per age; undefined → lowest index first.
